mem_data_align: RTL and testbench

- Byte-lane steering and extension block between the memory pipeline stage and the bidirectional 64-bit memory data bus.
- On stores and coprocessor transfers it drives the bus with correctly replicated store data.
- On every cycle it extracts, rotates and sign/zero-extends load data from the bus according to endianness, access size and the low address bits.
- The datapath is purely combinational; clock and reset exist for interface uniformity and bus safety.

---
 rtl/mem_data_align.sv | 46 ++++
 tb/tb_mem_data_align.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_data_align.sv
// mem_data_align: store-data lane replication onto the memory bus and load extraction/rotation/extension from it.
module mem_data_align (
  input  logic        nGCLK,
  input  logic        nRESET,
  input  logic [63:0] data,
  inout  wire  [63:0] data_bus,
  input  logic [1:0]  addr_low,
  output logic [63:0] loaded_data,
  input  logic        BIGEND,
  input  logic        out_ena,
  input  logic        unsigned_byte,
  input  logic        signed_byte,
  input  logic        unsigned_hw,
  input  logic        signed_hw
);
  logic        unused_clk;
  logic        is_byte, is_hw;
  logic [1:0]  lane;
  logic [31:0] bus_lo, st_lo, ld_lo, rot_r, rot_l;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [63:0] dbl, dbl_r, dbl_l;
  assign unused_clk = nGCLK;
  assign is_byte = signed_byte | unsigned_byte;
  assign is_hw = signed_hw | unsigned_hw;
  // Replication is lane-agnostic; the memory picks the byte/half it wants.
  assign st_lo = is_byte ? {4{data[7:0]}} : is_hw ? {2{data[15:0]}} : data[31:0];
  assign data_bus = (nRESET && out_ena) ? {data[63:32], st_lo} : 64'bz;
  assign bus_lo = data_bus[31:0];
  assign lane = BIGEND ? ~addr_low : addr_low;
  assign bsel = bus_lo[{lane, 3'b000} +: 8];
  assign hsel = (addr_low[1] ^ BIGEND) ? bus_lo[31:16] : bus_lo[15:0];
  assign dbl = {bus_lo, bus_lo};
  assign dbl_r = dbl >> {addr_low, 3'b000};
  assign dbl_l = dbl << {addr_low, 3'b000};
  assign rot_r = dbl_r[31:0];
  assign rot_l = dbl_l[63:32];
  always_comb begin
    ld_lo = signed_byte   ? {{24{bsel[7]}}, bsel} :
            unsigned_byte ? {24'h0, bsel} :
            signed_hw     ? {{16{hsel[15]}}, hsel} :
            unsigned_hw   ? {16'h0, hsel} :
            BIGEND        ? rot_l : rot_r;
  end
  assign loaded_data = nRESET ? {data_bus[63:32], ld_lo} : 64'h0;
endmodule

// File: tb/tb_mem_data_align.sv
// tb_mem_data_align: table vectors, reset sequence and randomized checks against a byte-level reference model.
module tb_mem_data_align;
  logic        clk = 0, nrst, oe, big, sb, ub, sh, uh, tb_en;
  logic [1:0]  a;
  logic [63:0] data, tb_drv, ld;
  wire  [63:0] bus;
  int checks = 0, failures = 0;

  assign bus = tb_en ? tb_drv : 64'bz;
  always #5 clk = ~clk;

  mem_data_align dut (
    .nGCLK(clk), .nRESET(nrst), .data(data), .data_bus(bus), .addr_low(a),
    .loaded_data(ld), .BIGEND(big), .out_ena(oe), .unsigned_byte(ub),
    .signed_byte(sb), .unsigned_hw(uh), .signed_hw(sh)
  );

  typedef struct {
    logic nrst, oe, big, sb, ub, sh, uh;
    logic [1:0] a;
    logic [63:0] data, bus_in, exp_bus, exp_ld;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_bus(input logic [63:0] d, input logic b_byte, input logic b_hw);
    logic [31:0] lo;
    if (b_byte) lo = 32'(d[7:0]) * 32'h01010101;
    else if (b_hw) lo = 32'(d[15:0]) * 32'h00010001;
    else lo = d[31:0];
    return {d[63:32], lo};
  endfunction

  function automatic logic [63:0] model_ld(input logic [63:0] b_in, input logic r, input logic be,
                                           input logic [1:0] ad, input logic s_b, input logic u_b,
                                           input logic s_h, input logic u_h);
    logic [7:0]  bt [4];
    logic [31:0] lo;
    logic [15:0] hv;
    int lane, h, off;
    if (!r) return 64'h0;
    for (int i = 0; i < 4; i++) bt[i] = b_in[8*i +: 8];
    off = int'(ad);
    lane = be ? 3 - off : off;
    h = ((off >= 2) != be) ? 1 : 0;
    lo = 32'h0;
    if (s_b || u_b) begin
      lo = {24'h0, bt[lane]};
      if (s_b && bt[lane] >= 8'h80) lo = lo | 32'hFFFFFF00;
    end else if (s_h || u_h) begin
      hv = b_in[16*h +: 16];
      lo = {16'h0, hv};
      if (s_h && hv >= 16'h8000) lo = lo | 32'hFFFF0000;
    end else begin
      for (int i = 0; i < 4; i++) lo[8*i +: 8] = be ? bt[(i - off + 4) % 4] : bt[(i + off) % 4];
    end
    return {b_in[63:32], lo};
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    nrst = v.nrst; oe = v.oe; big = v.big; a = v.a;
    sb = v.sb; ub = v.ub; sh = v.sh; uh = v.uh;
    data = v.data; tb_drv = v.bus_in;
    tb_en = !(v.nrst && v.oe);
    #1;
  endtask

  vec_t tbl [19];
  vec_t v;

  initial begin
    //          nrst oe big sb ub sh uh  a    data                   bus_in                 exp_bus                exp_ld
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 2'd0, 64'h11223344_55667788, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, 64'h0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 2'd0, 64'h11223344_55667788, 64'h0, 64'h11223344_55667788, 64'h11223344_55667788};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 2'd0, 64'hCAFEBABE_DEADBEEF, 64'h0, 64'hCAFEBABE_DEADBEEF, 64'hCAFEBABE_DEADBEEF};
    tbl[3]  = '{1, 1, 0, 0, 1, 0, 0, 2'd0, 64'h00000000_000000A5, 64'h0, 64'h00000000_A5A5A5A5, 64'h00000000_000000A5};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 1, 2'd0, 64'h00000000_00001234, 64'h0, 64'h00000000_12341234, 64'h00000000_00001234};
    tbl[5]  = '{1, 0, 0, 1, 0, 0, 0, 2'd0, 64'h0, 64'h00000000_80FF7F01, 64'h00000000_80FF7F01, 64'h00000000_00000001};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 0, 2'd2, 64'h0, 64'h00000000_80FF7F01, 64'h00000000_80FF7F01, 64'h00000000_FFFFFFFF};
    tbl[7]  = '{1, 0, 0, 1, 0, 0, 0, 2'd3, 64'h0, 64'h00000000_80FF7F01, 64'h00000000_80FF7F01, 64'h00000000_FFFFFF80};
    tbl[8]  = '{1, 0, 1, 1, 0, 0, 0, 2'd0, 64'h0, 64'h00000000_80FF7F01, 64'h00000000_80FF7F01, 64'h00000000_FFFFFF80};
    tbl[9]  = '{1, 0, 0, 0, 1, 0, 0, 2'd3, 64'h0, 64'h00000000_80FF7F01, 64'h00000000_80FF7F01, 64'h00000000_00000080};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 2'd2, 64'h0, 64'h00000000_80017FFE, 64'h00000000_80017FFE, 64'h00000000_FFFF8001};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 1, 2'd2, 64'h0, 64'h00000000_80017FFE, 64'h00000000_80017FFE, 64'h00000000_00008001};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 0, 2'd0, 64'h0, 64'h00000000_80017FFE, 64'h00000000_80017FFE, 64'h00000000_00007FFE};
    tbl[13] = '{1, 0, 1, 0, 0, 1, 0, 2'd0, 64'h0, 64'h00000000_80017FFE, 64'h00000000_80017FFE, 64'h00000000_FFFF8001};
    tbl[14] = '{1, 0, 1, 0, 0, 1, 0, 2'd3, 64'h0, 64'h00000000_80017FFE, 64'h00000000_80017FFE, 64'h00000000_00007FFE};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 2'd1, 64'h0, 64'h99887766_44332211, 64'h99887766_44332211, 64'h99887766_11443322};
    tbl[16] = '{1, 0, 1, 0, 0, 0, 0, 2'd1, 64'h0, 64'h99887766_44332211, 64'h99887766_44332211, 64'h99887766_33221144};
    tbl[17] = '{1, 0, 0, 1, 0, 0, 1, 2'd3, 64'h0, 64'h00000000_80FF7F01, 64'h00000000_80FF7F01, 64'h00000000_FFFFFF80};
    tbl[18] = '{1, 1, 0, 1, 0, 1, 0, 2'd0, 64'h00000000_0000C3D4, 64'h0, 64'h00000000_D4D4D4D4, 64'h00000000_FFFFFFD4};
    nrst = 0; oe = 0; big = 0; a = 0; sb = 0; ub = 0; sh = 0; uh = 0;
    data = 0; tb_drv = 0; tb_en = 1;
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_bus", i), bus, tbl[i].exp_bus);
      check($sformatf("vec%0d_ld", i), ld, tbl[i].exp_ld);
    end
    // Asynchronous reset assert/release mid-cycle with the block wanting to drive.
    @(negedge clk);
    tb_en = 0; oe = 1; sb = 0; ub = 0; sh = 0; uh = 0; a = 0; big = 0;
    data = 64'h11223344_55667788;
    #1 check("drive_before_reset", bus, 64'h11223344_55667788);
    #1 nrst = 0;
    #1 check("async_reset_ld", ld, 64'h0);
    tb_en = 1; tb_drv = 64'h0F0F0F0F_F0F0F0F0;
    #1 check("reset_bus_released", bus, 64'h0F0F0F0F_F0F0F0F0);
    check("reset_ld_gated", ld, 64'h0);
    tb_en = 0;
    #1 nrst = 1;
    #1 check("release_bus", bus, 64'h11223344_55667788);
    check("release_ld", ld, 64'h11223344_55667788);
    // Randomized against the reference model.
    for (int n = 0; n < 300; n++) begin
      v.nrst = ($urandom_range(0, 15) != 0);
      v.oe = $urandom_range(0, 1);
      v.big = $urandom_range(0, 1);
      v.a = 2'($urandom_range(0, 3));
      v.sb = ($urandom_range(0, 3) == 0);
      v.ub = ($urandom_range(0, 3) == 0);
      v.sh = ($urandom_range(0, 3) == 0);
      v.uh = ($urandom_range(0, 3) == 0);
      v.data = {$urandom, $urandom};
      v.bus_in = {$urandom, $urandom};
      v.exp_bus = (v.nrst && v.oe) ? model_bus(v.data, v.sb || v.ub, v.sh || v.uh) : v.bus_in;
      v.exp_ld = model_ld(v.exp_bus, v.nrst, v.big, v.a, v.sb, v.ub, v.sh, v.uh);
      apply(v);
      check($sformatf("rnd%0d_bus", n), bus, v.exp_bus);
      check($sformatf("rnd%0d_ld", n), ld, v.exp_ld);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
